xadac_obi_vmem: RTL and testbench
=================================

# xadac_obi_vmem

OBI subordinate that serves the 128-bit vector-memory requests issued by the xadac accelerator. It is a word-addressed, byte-enabled SRAM with a fixed-latency, in-order response pipeline and address-range/alignment error reporting. It sits on the accelerator's private OBI port as local scratchpad, and doubles as the memory model in xadac testbenches. Its channel widths match the package `ObiCfg`: 32-bit address, 128-bit data, 4-bit ID, minimal optional signals, no `rready`.

## Interface
Parameters:
- `Depth`, 1024 — number of 128-bit words; power of two, ≥ 2.
- `BaseAddr`, 32'h0000_0000 — byte address of word 0; aligned to `Depth*16`.
- `Latency`, 1 — grant-to-`rvalid_o` cycles; legal range 1..4.

Ports:
- `clk_i` in 1 — clock.
- `rst_ni` in 1 — asynchronous, active-low reset.
- `req_i` in 1 — A-channel request.
- `gnt_o` out 1 — A-channel grant.
- `addr_i` in 32 — byte address.
- `we_i` in 1 — 1 = write, 0 = read.
- `be_i` in 16 — byte enables; bit k covers `wdata_i[8k+7:8k]`.
- `wdata_i` in 128 — write data.
- `aid_i` in 4 — transaction ID.
- `rvalid_o` out 1 — response valid, single-cycle pulse per transaction.
- `rdata_o` out 128 — read data; 0 for writes and errors.
- `rid_o` out 4 — ID echoed from the granted request.
- `err_o` out 1 — error response.

## Operation
- Handshake: a transaction is accepted in a cycle where `req_i && gnt_o`. The initiator holds `req_i` and the A-channel signals stable until granted.
- Offset = `addr_i - BaseAddr`. The transaction is an error if `addr_i[3:0] != 0`, if `addr_i < BaseAddr`, or if offset ≥ `Depth*16`. Index = offset[`$clog2(Depth)+3`:4].
- Accepted write, no error: for each set bit of `be_i`, the byte at `mem[index]` is written at the accepting clock edge. `be_i == 0` writes nothing and still gets a response.
- Accepted read, no error: `mem[index]` is sampled at the accepting edge.
- Errored transactions never modify the array. They respond with `err_o=1`, `rdata_o=0`.
- Response pipeline: a `Latency`-stage shift register of {valid, id, err, data}. Stage 0 loads on accept; the last stage drives the outputs. Responses are strictly in acceptance order. With no `rready`, responses are never back-pressured.
- Ordering: a read accepted one or more cycles after a write to the same index returns the written data. A write-then-read in consecutive cycles needs no forwarding, since the array is updated at the write's accept edge.
- Array contents are not reset and are undefined after power-up.

## Timing
- Without the stall feature, `gnt_o` = 1 whenever `rst_ni` = 1.
- Throughput: one transaction per cycle.
- Accept at edge N → `rvalid_o` = 1 during the cycle after edge N+`Latency`-1. For `Latency`=1, the response is visible in the cycle following the accept edge.
- Reset values: `gnt_o`=0 (while `rst_ni`=0), `rvalid_o`=0, `rdata_o`=0, `rid_o`=0, `err_o`=0. All pipeline valids are cleared.
- Reset mid-operation: in-flight responses are discarded and no `rvalid_o` is produced for them. Writes already accepted remain in the array.
- When no response is due, `rvalid_o`=0 and `rdata_o`/`rid_o`/`err_o` are 0.

## Configuration
- `XADAC_VMEM_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; shifts left; seed 16'hACE1 at reset) advances every cycle.
  - `gnt_o` = `rst_ni && (lfsr[1:0] != 2'b00)`, a registered stall pattern used to exercise initiator grant handling.
  - Response latency measured from accept is unchanged.
- Not defined: the LFSR is absent and `gnt_o` = `rst_ni`.

## Test plan
- Write `addr`=0x10, `be`=16'hFFFF, `wdata`=0x00112233_44556677_8899AABB_CCDDEEFF, `aid`=3 → `rvalid_o` after `Latency`, `rid_o`=3, `err_o`=0, `rdata_o`=0. A later read of 0x10 with `aid`=5 returns that data with `rid_o`=5.
- Partial write `be`=16'h000F, `wdata`=all-ones onto a word of zeros → read returns 0x0000…0000_FFFFFFFF.
- Back-to-back stream: write 0x20, read 0x20, read 0x30 in three consecutive cycles with ids 1,2,3 → three consecutive `rvalid_o` pulses, ids 1,2,3 in order. The 0x20 read returns the newly written data.
- Errors: `addr`=0x24 (misaligned) and `addr`=`BaseAddr`+`Depth*16` → `err_o`=1, `rdata_o`=0, and the array is unchanged (verified by read-back).
- Assert `rst_ni`=0 with 2 reads in flight (`Latency`=3) → no `rvalid_o` for them. Outputs are 0 during and after reset until a new accept.
- With `XADAC_VMEM_STALL_EN`: hold `req_i` for 64 cycles → `gnt_o` follows the LFSR pattern from seed 16'hACE1 (first cycle granted). Each grant yields exactly one response at `Latency`.

Source files
------------

// File: rtl/xadac_obi_vmem.sv
`default_nettype none
// ============================================================================
// Module      : xadac_obi_vmem
// Description : OBI subordinate for xadac 128-bit vector-memory requests.
//               Word-addressed, byte-enabled SRAM with a fixed-latency,
//               in-order response pipeline and range/alignment errors.
//               Optional feature macro: XADAC_VMEM_STALL_EN (LFSR-driven
//               grant stalls for exercising initiator grant handling).
// Revision    : 1.0 - initial release
// ============================================================================
module xadac_obi_vmem #(
  parameter int unsigned Depth    = 1024,
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned Latency  = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_i,
  output logic         gnt_o,
  input  logic [31:0]  addr_i,
  input  logic         we_i,
  input  logic [15:0]  be_i,
  input  logic [127:0] wdata_i,
  input  logic [3:0]   aid_i,
  output logic         rvalid_o,
  output logic [127:0] rdata_o,
  output logic [3:0]   rid_o,
  output logic         err_o
);

  localparam int unsigned c_idx_w       = $clog2(Depth);
  localparam logic [31:0] c_depth_words = 32'(Depth);

  typedef struct packed {
    logic         valid;
    logic [3:0]   id;
    logic         err;
    logic [127:0] data;
  } resp_t;

  logic [127:0]       r_mem [Depth];
  resp_t              r_pipe [Latency];
  logic [31:0]        w_offset;
  logic               w_err;
  logic               w_accept;
  logic [c_idx_w-1:0] w_index;
  resp_t              w_stage0;

`ifdef XADAC_VMEM_STALL_EN
  logic [15:0] r_lfsr;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) producing the stall pattern
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign gnt_o = rst_ni && (r_lfsr[1:0] != 2'b00);
`else
  assign gnt_o = rst_ni;
`endif

  assign w_accept = req_i && gnt_o;

  // Address decode: offset into the window, error flags and word index
  always_comb begin
    w_offset = addr_i - BaseAddr;
    w_err    = (addr_i[3:0] != 4'h0) ||
               (addr_i < BaseAddr) ||
               ({4'h0, w_offset[31:4]} >= c_depth_words);
    w_index  = w_offset[c_idx_w+3:4];
  end

  // Build the response entering stage 0; idle cycles load an all-zero entry
  // so the outputs read zero whenever nothing is due.
  always_comb begin
    w_stage0 = '0;
    if (w_accept) begin
      w_stage0.valid = 1'b1;
      w_stage0.id    = aid_i;
      w_stage0.err   = w_err;
      w_stage0.data  = (!we_i && !w_err) ? r_mem[w_index] : '0;
    end
  end

  // Byte-enabled array write at the accepting edge; errors never write
  always_ff @(posedge clk_i) begin
    if (w_accept && we_i && !w_err) begin
      for (int k = 0; k < 16; k++) begin
        if (be_i[k]) begin
          r_mem[w_index][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Fixed-latency response shift register; reset discards in-flight entries
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Latency; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_stage0;
      for (int i = 1; i < Latency; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign rvalid_o = r_pipe[Latency-1].valid;
  assign rid_o    = r_pipe[Latency-1].id;
  assign err_o    = r_pipe[Latency-1].err;
  assign rdata_o  = r_pipe[Latency-1].data;

endmodule
`default_nettype wire

// File: tb/tb_xadac_obi_vmem.sv
`default_nettype none
// ============================================================================
// Module      : tb_xadac_obi_vmem
// Description : Self-checking bench for xadac_obi_vmem. A transaction-level
//               memory model predicts every response; literal expectations
//               pin key results. Honours XADAC_VMEM_STALL_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xadac_obi_vmem;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          LAT   = 3;

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic         gnt;
  logic [31:0]  addr;
  logic         we;
  logic [15:0]  be;
  logic [127:0] wdata;
  logic [3:0]   aid;
  logic         rvalid;
  logic [127:0] rdata;
  logic [3:0]   rid;
  logic         err;

  xadac_obi_vmem #(
    .Depth   (DEPTH),
    .BaseAddr(BASE),
    .Latency (LAT)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .gnt_o   (gnt),
    .addr_i  (addr),
    .we_i    (we),
    .be_i    (be),
    .wdata_i (wdata),
    .aid_i   (aid),
    .rvalid_o(rvalid),
    .rdata_o (rdata),
    .rid_o   (rid),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int           due;
    logic [3:0]   id;
    logic         err;
    logic [127:0] data;
  } exp_t;

  exp_t         q[$];
  logic [127:0] mm[int];
  int           cyc     = 0;
  int           acc_cnt = 0;
  logic         gnt_exp;

`ifdef XADAC_VMEM_STALL_EN
  logic [15:0] lfsr = 16'hACE1;
  assign gnt_exp = rst_n && (lfsr[1:0] != 2'b00);
`else
  assign gnt_exp = rst_n;
`endif

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n === 1'b1) begin
        if (req && gnt_exp) begin
          exp_t        e;
          longint      a;
          int          idx;
          logic [127:0] w;
          a     = longint'(addr);
          e.due = cyc + LAT - 1;
          e.id  = aid;
          e.err = (a % 16 != 0) || (a < longint'(BASE)) ||
                  (a - longint'(BASE) >= DEPTH * 16);
          idx   = int'((a - longint'(BASE)) / 16);
          e.data = '0;
          if (!e.err) begin
            if (we) begin
              w = mm.exists(idx) ? mm[idx] : 'x;
              for (int k = 0; k < 16; k++)
                if (be[k]) w[8*k +: 8] = wdata[8*k +: 8];
              mm[idx] = w;
            end else begin
              e.data = mm.exists(idx) ? mm[idx] : 'x;
            end
          end
          q.push_back(e);
          acc_cnt++;
        end
`ifdef XADAC_VMEM_STALL_EN
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
      end else begin
`ifdef XADAC_VMEM_STALL_EN
        lfsr = 16'hACE1;
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [127:0] log_data[16];
  logic         log_err[16];
  int           log_cyc[16];
  int           resp_cnt = 0;

  initial begin
    forever begin
      logic         ev;
      exp_t         e;
      @(negedge clk);
      if (rst_n !== 1'b1) q.delete();
      ev = (q.size() > 0) && (q[0].due == cyc);
      e.id = '0; e.err = 1'b0; e.data = '0;
      if (ev) e = q.pop_front();
      chk("gnt",    gnt,    gnt_exp);
      chk("rvalid", rvalid, ev);
      chk("rid",    rid,    e.id);
      chk("err",    err,    e.err);
      chk("rdata",  rdata,  e.data);
      if (rvalid === 1'b1) begin
        log_data[rid] = rdata;
        log_err[rid]  = err;
        log_cyc[rid]  = cyc;
        resp_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic w, input logic [31:0] a, input logic [15:0] b,
                       input logic [127:0] d, input logic [3:0] id);
    logic g;
    req = 1'b1; we = w; addr = a; be = b; wdata = d; aid = id;
    for (int t = 0; t < 100; t++) begin
      g = gnt_exp;
      @(negedge clk); #1;
      if (g) return;
    end
    chk("grant_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; aid = '0;
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 16; i++) begin
      log_data[i] = 'x;
      log_err[i]  = 1'bx;
      log_cyc[i]  = -100;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, a0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; aid = '0;
    clear_log();
    repeat (3) @(negedge clk);
    chk("reset_gnt", gnt, 1'b0);
    chk("reset_rvalid", rvalid, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;

    // zero the words used below (including error-alias targets)
    issue(1, BASE + 32'h000, 16'hFFFF, '0, 0);
    issue(1, BASE + 32'h010, 16'hFFFF, '0, 0);
    issue(1, BASE + 32'h020, 16'hFFFF, '0, 0);
    issue(1, BASE + 32'h030, 16'hFFFF, '0, 0);
    issue(1, BASE + 32'h040, 16'hFFFF, '0, 0);
    issue(1, BASE + 32'hFF0, 16'hFFFF, '0, 0);
    idle(LAT + 2);

    // full write then read-back
    clear_log();
    issue(1, BASE + 32'h10, 16'hFFFF, D1, 3);
    idle(LAT + 2);
    chk("wr_err", log_err[3], 1'b0);
    chk("wr_rdata_zero", log_data[3], '0);
    issue(0, BASE + 32'h10, 16'h0000, '0, 5);
    idle(LAT + 2);
    chk("rd_back", log_data[5], D1);

    // partial write onto zeros
    issue(1, BASE + 32'h40, 16'h000F, {128{1'b1}}, 6);
    issue(0, BASE + 32'h40, 16'h0000, '0, 7);
    idle(LAT + 2);
    chk("partial", log_data[7], 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);

    // back-to-back stream
    clear_log();
    issue(1, BASE + 32'h20, 16'hFFFF, D2, 1);
    issue(0, BASE + 32'h20, 16'h0000, '0, 2);
    issue(0, BASE + 32'h30, 16'h0000, '0, 3);
    idle(LAT + 2);
    chk("b2b_rd20", log_data[2], D2);
    chk("b2b_rd30", log_data[3], '0);
`ifndef XADAC_VMEM_STALL_EN
    chk("b2b_gap12", 128'(log_cyc[2] - log_cyc[1]), 128'd1);
    chk("b2b_gap23", 128'(log_cyc[3] - log_cyc[2]), 128'd1);
`endif

    // error cases: misaligned, past end, below base; none may write
    clear_log();
    issue(1, BASE + 32'h24,   16'hFFFF, {128{1'b1}}, 7);
    issue(1, BASE + 32'h1000, 16'hFFFF, {128{1'b1}}, 8);
    issue(1, BASE - 32'h10,   16'hFFFF, {128{1'b1}}, 9);
    issue(0, BASE + 32'h1008, 16'h0000, '0, 13);
    issue(0, BASE + 32'h20,   16'h0000, '0, 10);
    issue(0, BASE + 32'h000,  16'h0000, '0, 11);
    issue(0, BASE + 32'hFF0,  16'h0000, '0, 12);
    idle(LAT + 2);
    chk("err_misaligned", log_err[7], 1'b1);
    chk("err_misaligned_data", log_data[7], '0);
    chk("err_past_end", log_err[8], 1'b1);
    chk("err_below_base", log_err[9], 1'b1);
    chk("err_read_data", log_data[13], '0);
    chk("unchanged_20", log_data[10], D2);
    chk("unchanged_00", log_data[11], '0);
    chk("unchanged_ff0", log_data[12], '0);

    // reset with two reads in flight
    clear_log();
    r0 = resp_cnt;
    issue(0, BASE + 32'h10, 16'h0000, '0, 14);
    issue(0, BASE + 32'h20, 16'h0000, '0, 15);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(LAT + 2);
    chk("reset_drop", 128'(resp_cnt - r0), 128'd0);
    issue(0, BASE + 32'h10, 16'h0000, '0, 4);
    idle(LAT + 2);
    chk("write_survives_reset", log_data[4], D1);

    // hold a request continuously
    r0 = resp_cnt;
    a0 = acc_cnt;
    req = 1'b1; we = 1'b0; addr = BASE + 32'h20; be = '0; wdata = '0; aid = 4'hA;
    repeat (64) begin
      @(negedge clk); #1;
    end
    idle(LAT + 2);
    chk("hold_resp_count", 128'(resp_cnt - r0), 128'(acc_cnt - a0));
`ifndef XADAC_VMEM_STALL_EN
    chk("hold_accepts", 128'(resp_cnt - r0), 128'd64);
`endif
    chk("hold_data", log_data[10], D2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
